mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) in front of a single memory port.
// Data wins contention, but only for MAX_D_STREAK consecutive grants while a fetch is waiting.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wmask,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE_I = 3'd1;
    localparam logic [2:0] ISSUE_D = 3'd2;
    localparam logic [2:0] WAIT_I  = 3'd3;
    localparam logic [2:0] WAIT_D  = 3'd4;

    logic [2:0]    state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          d_wins;

    // Handshake: a request is accepted in the cycle mem_req && mem_ready; the single
    // outstanding response is the first mem_rvalid seen afterwards in the WAIT state.
    assign d_wins   = d_req && !(if_req && (streak == SW'(MAX_D_STREAK)));
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = 4'h0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (d_wins)      state_nxt = ISSUE_D;
                else if (if_req) state_nxt = ISSUE_I;
            end
            ISSUE_I: begin
                mem_req  = 1'b1;
                mem_addr = if_addr;
                if (mem_ready) begin
                    if_gnt    = 1'b1;
                    state_nxt = WAIT_I;
                end
            end
            ISSUE_D: begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wmask = d_wmask;
                if (mem_ready) begin
                    d_gnt     = 1'b1;
                    state_nxt = WAIT_D;
                end
            end
            WAIT_I: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    d_rvalid  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Streak counts data grants handed out while a fetch was kept waiting.
    always_comb begin
        streak_nxt = streak;
        if (d_gnt) begin
            if (!if_req)                            streak_nxt = '0;
            else if (streak != SW'(MAX_D_STREAK))   streak_nxt = streak + SW'(1);
        end
        if (if_gnt) streak_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

endmodule
